// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB PWM sequencer: mode and colour-cycle phase
// encodings plus the manual-mode dimming shift.
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_FADE   = 2'd1,
        MODE_CYCLE  = 2'd2,
        MODE_MANUAL = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        PH_RG = 2'd0,
        PH_GB = 2'd1,
        PH_BR = 2'd2
    } phase_t;

    localparam int MANUAL_LO_SHIFT = 2;

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchronizer, stability counter, debounced level and a
// single-cycle press pulse on each debounced rising edge.
module btn_debounce #(
    parameter int CYC = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(CYC + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // NOTE: non-blocking assignments make every flop sample its pre-edge value; with
    // blocking ones the two synchronizer stages would collapse into a single flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYC - 1)) begin
                level <= sync[1];
                press <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Mode-driven controller for two RGB LEDs: debounced buttons select OFF/FADE/CYCLE/MANUAL,
// and a shared free-running counter turns the working duties into six PWM outputs.
module rgb_pwm_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int CLK_FREQ    = 12000000,
    parameter int PWM_BITS    = 8,
    parameter int STEP_MS     = 10,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [3:0] sw,
    output logic       led0_r,
    output logic       led0_g,
    output logic       led0_b,
    output logic       led1_r,
    output logic       led1_g,
    output logic       led1_b,
    output logic [1:0] mode,
    output logic       paused
);

    localparam int STEP_CYC = CLK_FREQ / 1000 * STEP_MS;
    localparam int DB_CYC   = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int PCW      = $clog2(STEP_CYC + 1);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_TOP = DUTY_MAX - DUTY_ONE;
    localparam logic [PWM_BITS-1:0] DUTY_LO  = DUTY_MAX >> MANUAL_LO_SHIFT;

    logic [3:0] sw_s1, sw_s2;
    logic [3:0] db_level, db_press, btn_evt;

    logic [PCW-1:0] pre_cnt;
    logic           tick;

    mode_t               cur_mode, mode_nx;
    logic                paused_nx;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
    logic [PWM_BITS-1:0] duty_r_nx, duty_g_nx, duty_b_nx;
    logic                dir_down, dir_down_nx;
    phase_t              phase, phase_nx;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] act_r, act_g, act_b;
    logic                act_off;
    logic [PWM_BITS-1:0] man_lvl;

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(.CYC(DB_CYC)) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[i]),
            .level (db_level[i]),
            .press (db_press[i])
        );
    end

    // The pulse is only ever raised together with the level; qualifying keeps both in use.
    assign btn_evt = db_press & db_level;
    assign tick    = (pre_cnt == PCW'(STEP_CYC - 1));
    assign mode    = cur_mode;
    assign man_lvl = sw_s2[3] ? DUTY_MAX : DUTY_LO;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            pre_cnt <= '0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_mode <= MODE_OFF;
            paused   <= 1'b0;
            duty_r   <= '0;
            duty_g   <= '0;
            duty_b   <= '0;
            dir_down <= 1'b0;
            phase    <= PH_RG;
        end else begin
            cur_mode <= mode_nx;
            paused   <= paused_nx;
            duty_r   <= duty_r_nx;
            duty_g   <= duty_g_nx;
            duty_b   <= duty_b_nx;
            dir_down <= dir_down_nx;
            phase    <= phase_nx;
        end
    end

    // NOTE: every next-state signal is given its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    always_comb begin
        mode_nx     = cur_mode;
        paused_nx   = paused;
        duty_r_nx   = duty_r;
        duty_g_nx   = duty_g;
        duty_b_nx   = duty_b;
        dir_down_nx = dir_down;
        phase_nx    = phase;

        if (btn_evt[3] || btn_evt[0] || btn_evt[1]) begin
            if (btn_evt[3])      mode_nx = MODE_OFF;
            else if (btn_evt[0]) mode_nx = mode_t'(cur_mode + 2'd1);
            else                 mode_nx = mode_t'(cur_mode - 2'd1);
            paused_nx   = 1'b0;
            duty_r_nx   = (mode_nx == MODE_CYCLE) ? DUTY_MAX : '0;
            duty_g_nx   = '0;
            duty_b_nx   = '0;
            dir_down_nx = 1'b0;
            phase_nx    = PH_RG;
        end else if (btn_evt[2]) begin
            if (cur_mode == MODE_FADE || cur_mode == MODE_CYCLE) paused_nx = ~paused;
        end else if (cur_mode == MODE_MANUAL) begin
            duty_r_nx = sw_s2[0] ? man_lvl : '0;
            duty_g_nx = sw_s2[1] ? man_lvl : '0;
            duty_b_nx = sw_s2[2] ? man_lvl : '0;
        end else if (tick && !paused) begin
            if (cur_mode == MODE_FADE) begin
                if (!dir_down) begin
                    duty_r_nx = duty_r + DUTY_ONE;
                    if (duty_r == DUTY_TOP) dir_down_nx = 1'b1;
                end else begin
                    duty_r_nx = duty_r - DUTY_ONE;
                    if (duty_r == DUTY_ONE) dir_down_nx = 1'b0;
                end
            end else if (cur_mode == MODE_CYCLE) begin
                unique case (phase)
                    PH_RG: begin
                        duty_g_nx = duty_g + DUTY_ONE;
                        duty_r_nx = duty_r - DUTY_ONE;
                        if (duty_g == DUTY_TOP) phase_nx = PH_GB;
                    end
                    PH_GB: begin
                        duty_b_nx = duty_b + DUTY_ONE;
                        duty_g_nx = duty_g - DUTY_ONE;
                        if (duty_b == DUTY_TOP) phase_nx = PH_BR;
                    end
                    PH_BR: begin
                        duty_r_nx = duty_r + DUTY_ONE;
                        duty_b_nx = duty_b - DUTY_ONE;
                        if (duty_r == DUTY_TOP) phase_nx = PH_RG;
                    end
                    default: phase_nx = PH_RG;
                endcase
            end
        end
    end

    // Active duties only move at the period boundary so a period is never cut short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            act_r   <= '0;
            act_g   <= '0;
            act_b   <= '0;
            act_off <= 1'b1;
            led0_r  <= 1'b0;
            led0_g  <= 1'b0;
            led0_b  <= 1'b0;
            led1_r  <= 1'b0;
            led1_g  <= 1'b0;
            led1_b  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_ONE;
            if (pwm_cnt == DUTY_MAX) begin
                act_r   <= duty_r;
                act_g   <= duty_g;
                act_b   <= duty_b;
                act_off <= (cur_mode == MODE_OFF);
            end
            led0_r <= (pwm_cnt < act_r);
            led0_g <= (pwm_cnt < act_g);
            led0_b <= (pwm_cnt < act_b);
            led1_r <= !act_off && (pwm_cnt < (DUTY_MAX - act_r));
            led1_g <= !act_off && (pwm_cnt < (DUTY_MAX - act_g));
            led1_b <= !act_off && (pwm_cnt < (DUTY_MAX - act_b));
        end
    end

endmodule

// File: doc/rgb_pwm_sequencer.md
# rgb_pwm_sequencer

Mode-driven controller for the Arty S7 test design's two RGB LEDs. Debounces the four push buttons, runs a mode state machine (off / fade / color-cycle / manual), and drives six PWM outputs from one shared free-running PWM counter. It sits between the board pins (btn, sw) and the led0_*/led1_* pins of the top-level test wrapper.

## Interface
- CLK_FREQ, 12000000: clock frequency in Hz.
- PWM_BITS, 8: duty resolution; PWM period is 2^PWM_BITS cycles.
- STEP_MS, 10: interval between duty steps in FADE/CYCLE; STEP_CYC = CLK_FREQ/1000*STEP_MS.
- DEBOUNCE_MS, 20: button stability time; DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS.
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- btn  in  4  raw push buttons, asynchronous to clk; 1 = pressed.
- sw   in  4  raw slide switches, asynchronous to clk.
- led0_r, led0_g, led0_b  out  1 each  RGB LED 0 PWM, registered.
- led1_r, led1_g, led1_b  out  1 each  RGB LED 1 PWM, registered.
- mode  out  2  current mode: 0 OFF, 1 FADE, 2 CYCLE, 3 MANUAL.
- paused  out  1  1 while FADE/CYCLE stepping is frozen.

## Operation
- Inputs: btn and sw each pass through a 2-flop synchronizer. Each button has a debouncer: the debounced level changes only after the synchronized level differs from it for DB_CYC consecutive cycles. A press event is a 1-cycle pulse on a debounced 0->1 transition.
- Button events, priority when simultaneous: btn[3] > btn[0] > btn[1] > btn[2]; only the highest event in a cycle is acted on, the others are dropped.
  - btn[3]: mode <= OFF.
  - btn[0]: mode <= mode+1, wrapping 3->0.
  - btn[1]: mode <= mode-1, wrapping 0->3.
  - btn[2]: toggles paused; it is a no-op in OFF/MANUAL.
- Any mode change clears paused and resets the sequence state: duty_r/g/b = 0, dir = up, phase = 0.
- Step tick: a prescaler pulses once every STEP_CYC cycles and is free-running from reset. Stepping happens only on a tick with paused = 0.
- OFF: all duties 0.
- FADE: duty_r steps +1 per tick up to 2^PWM_BITS-1, then -1 down to 0, then up again. Direction flips on the step that reaches an end. The value is not repeated at either end. duty_g = duty_b = 0.
- CYCLE: phase is 0 (R->G), 1 (G->B) or 2 (B->R). Each tick, the "to" color gets +1 and the "from" color gets -1. When "to" reaches max, phase advances mod 3.
  - Entry condition, first tick: duty_r = max is preloaded on entry.
- MANUAL: enable = synchronized sw[2:0] (r, g, b). Enabled colors run at duty max when sw[3] = 1, else max/4. Disabled colors run at 0.
- PWM: pwm_cnt is a PWM_BITS-bit free-running counter.
  - Active duties latch from the working duties only when pwm_cnt = max, so there are no mid-period glitches.
  - LED0 channel = (pwm_cnt < active_duty). LED1 uses the inverted duty (max - active_duty) per color, except in OFF, where all LED1 channels are 0.
  - Duty 0 means always off. Duty max means on for max of 2^PWM_BITS cycles.

## Timing
- Reset: all led outputs 0, mode = 0, paused = 0, all duties 0, pwm_cnt = 0, prescaler 0, debouncers at level 0.
- Button latency: debounced level rises DB_CYC cycles after the synchronized level rises. mode/paused update the cycle after the press pulse.
- New duties appear on the outputs at the first PWM period boundary after update, plus 1 register cycle.
- Reset asserted mid-operation returns every register to its reset value immediately. Behaviour restarts cleanly on deassert.
- Bounces shorter than DB_CYC produce no event.

## Structure
- Package rgb_seq_pkg holds:
  - the mode_t enum (OFF, FADE, CYCLE, MANUAL) and phase_t;
  - MANUAL_LO_SHIFT = 2.
- Sub-module btn_debounce (param CYC): synchronizer + counter, outputs level and press pulse. Instantiated 4x.

## Test plan
All scenarios use sim params CLK_FREQ=100000, STEP_MS=1 (100 cycles), DEBOUNCE_MS=1 (100 cycles), PWM_BITS=4.
1. Reset: hold rst for 5 cycles, then release. Expect all LEDs 0 and mode=0 for 1000 cycles.
2. btn[0] pulsed for 50 cycles (bounce): mode stays 0. Held for 150 cycles: mode=1 about 103 cycles after the rise. Three further presses: mode goes 2, 3, then wraps to 0.
3. FADE: duty_r counts 0 to 15 over 15 ticks, then 14 down to 0. At duty 4, led0_r is high for 4 of 16 cycles and led1_r for 11 of 16.
4. CYCLE: after 15 ticks duty_g=15 and duty_r=0, phase=1. After 45 ticks, back to phase 0 with duty_r=15.
5. Simultaneous press of btn[3] and btn[0] in FADE: mode=0. btn[2] in FADE freezes duty for 500 cycles; a second btn[2] press resumes stepping.
6. MANUAL with sw=4'b0101: led0_r and led0_b are high 3 of 16 cycles, led0_g is 0. Setting sw[3]=1 raises them to 15 of 16 cycles after the next period boundary.
